// File: rtl/id_decode_stage_pkg.sv
// Shared definitions for the decode stage: widths, ALU commands, opcodes and
// the decoded entry that travels through the output buffer.
package id_decode_stage_pkg;

    localparam int WORD_LEN     = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int IMM_FLAG_BIT = 5;

    typedef enum logic [3:0] {
        EXE_ADD = 4'd0,
        EXE_SUB = 4'd1,
        EXE_AND = 4'd2,
        EXE_OR  = 4'd3,
        EXE_XOR = 4'd4,
        EXE_NOR = 4'd5,
        EXE_SLA = 4'd6,
        EXE_SLL = 4'd7,
        EXE_SRA = 4'd8,
        EXE_SRL = 4'd9
    } execmd_t;

    typedef enum logic [5:0] {
        OP_NOP  = 6'h00,
        OP_ADD  = 6'h01, OP_SUB  = 6'h02, OP_AND  = 6'h03, OP_OR   = 6'h04,
        OP_XOR  = 6'h05, OP_NOR  = 6'h06, OP_SLA  = 6'h07, OP_SLL  = 6'h08,
        OP_SRA  = 6'h09, OP_SRL  = 6'h0A,
        OP_ADDI = 6'h21, OP_SUBI = 6'h22, OP_ANDI = 6'h23, OP_ORI  = 6'h24,
        OP_XORI = 6'h25, OP_NORI = 6'h26, OP_SLAI = 6'h27, OP_SLLI = 6'h28,
        OP_SRAI = 6'h29, OP_SRLI = 6'h2A
    } opcode_t;

    typedef struct packed {
        execmd_t               exe_cmd;
        logic [WORD_LEN-1:0]   val1;
        logic [WORD_LEN-1:0]   val2;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic                  illegal;
`endif
    } decoded_t;

    // EXE_ADD encodes as zero, so the all-zero entry is exactly the idle NOP.
    localparam decoded_t DECODED_IDLE = '0;

    function automatic logic op_is_alu(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
            OP_SLA, OP_SLL, OP_SRA, OP_SRL,
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_NORI,
            OP_SLAI, OP_SLLI, OP_SRAI, OP_SRLI: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic execmd_t op_to_cmd(input logic [5:0] op);
        case (op)
            OP_SUB, OP_SUBI: return EXE_SUB;
            OP_AND, OP_ANDI: return EXE_AND;
            OP_OR,  OP_ORI:  return EXE_OR;
            OP_XOR, OP_XORI: return EXE_XOR;
            OP_NOR, OP_NORI: return EXE_NOR;
            OP_SLA, OP_SLAI: return EXE_SLA;
            OP_SLL, OP_SLLI: return EXE_SLL;
            OP_SRA, OP_SRAI: return EXE_SRA;
            OP_SRL, OP_SRLI: return EXE_SRL;
            default:         return EXE_ADD;
        endcase
    endfunction

endpackage

// File: rtl/id_decode_stage_skid_buf.sv
// Two-entry valid/ready buffer (output register + skid) for decoded entries.
// in_ready is registered so the upstream handshake never sees out_ready combinationally.
module decode_skid_buf
    import id_decode_stage_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     in_valid,
    output logic     in_ready,
    input  decoded_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output decoded_t out_data
);

    logic     skid_valid;
    decoded_t skid_data;
    logic     accept;
    logic     main_free;

    assign accept    = in_valid & in_ready;
    assign main_free = !out_valid || out_ready;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
            out_data   <= DECODED_IDLE;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (main_free) begin
            // in_ready mirrors !skid_valid, so a full skid never coincides with accept.
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) out_data <= in_data;
            end
            in_ready <= 1'b1;
        end else if (accept) begin
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end

    // NOTE: skid payload needs no reset; it is only observed while skid_valid is set.
    always_ff @(posedge clk) begin
        if (!main_free && accept) skid_data <= in_data;
    end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction decode stage: combinational decode + register read, registered output
// through a 2-entry skid buffer. Optional macro DECODE_ILLEGAL_TRAP_EN adds the illegal flag.
module id_decode_stage
    import id_decode_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_LEN-1:0]   instr,
    output logic [REG_ADDR_W-1:0] rf_raddr1,
    output logic [REG_ADDR_W-1:0] rf_raddr2,
    input  logic [WORD_LEN-1:0]   rf_rdata1,
    input  logic [WORD_LEN-1:0]   rf_rdata2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output execmd_t               exe_cmd,
    output logic [WORD_LEN-1:0]   val1,
    output logic [WORD_LEN-1:0]   val2,
    output logic [REG_ADDR_W-1:0] dest,
    output logic                  wb_en
`ifdef DECODE_ILLEGAL_TRAP_EN
   ,output logic                  illegal
`endif
);

    logic [5:0]  opcode;
    logic [15:0] imm16;
    decoded_t    dec;
    decoded_t    out_data;

    assign opcode    = instr[31:26];
    assign imm16     = instr[15:0];
    assign rf_raddr1 = instr[20:16];
    assign rf_raddr2 = instr[15:11];

    // NOTE: dec gets a full default first so no path through the block infers a latch.
    always_comb begin
        dec = DECODED_IDLE;
        if (op_is_alu(opcode)) begin
            dec.exe_cmd = op_to_cmd(opcode);
            dec.val1    = rf_rdata1;
            dec.dest    = instr[25:21];
            dec.wb_en   = 1'b1;
            if (!opcode[IMM_FLAG_BIT]) begin
                dec.val2 = rf_rdata2;
            end else begin
                unique case (dec.exe_cmd)
                    EXE_ADD, EXE_SUB:
                        dec.val2 = {{(WORD_LEN-16){imm16[15]}}, imm16};
                    EXE_SLA, EXE_SLL, EXE_SRA, EXE_SRL:
                        dec.val2 = {{(WORD_LEN-5){1'b0}}, imm16[4:0]};
                    default:
                        dec.val2 = {{(WORD_LEN-16){1'b0}}, imm16};
                endcase
            end
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.illegal = (opcode != OP_NOP) && !op_is_alu(opcode);
`endif
    end

    decode_skid_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign exe_cmd = out_data.exe_cmd;
    assign val1    = out_data.val1;
    assign val2    = out_data.val2;
    assign dest    = out_data.dest;
    assign wb_en   = out_data.wb_en;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal = out_data.illegal;
`endif

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: driver pushes expected entries on accept,
// a negedge monitor pops and compares on every output handshake.
module tb_id_decode_stage;
    import id_decode_stage_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [WORD_LEN-1:0]   instr = '0;
    logic [REG_ADDR_W-1:0] rf_raddr1, rf_raddr2;
    logic [WORD_LEN-1:0]   rf_rdata1 = '0, rf_rdata2 = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    execmd_t               exe_cmd;
    logic [WORD_LEN-1:0]   val1, val2;
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb_en;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                  illegal;
`endif

    id_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .out_valid(out_valid), .out_ready(out_ready),
        .exe_cmd(exe_cmd), .val1(val1), .val2(val2), .dest(dest), .wb_en(wb_en)
`ifdef DECODE_ILLEGAL_TRAP_EN
       ,.illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    decoded_t exp_q[$];
    decoded_t got;

    always @(posedge clk) cyc++;

    always_comb begin
        got.exe_cmd = exe_cmd;
        got.val1    = val1;
        got.val2    = val2;
        got.dest    = dest;
        got.wb_en   = wb_en;
`ifdef DECODE_ILLEGAL_TRAP_EN
        got.illegal = illegal;
`endif
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic decoded_t mk_exp(input execmd_t c, input logic [31:0] v1, input logic [31:0] v2,
                                        input logic [4:0] d, input logic wb, input logic ill);
        decoded_t e;
        e.exe_cmd = c;
        e.val1    = v1;
        e.val2    = v2;
        e.dest    = d;
        e.wb_en   = wb;
`ifdef DECODE_ILLEGAL_TRAP_EN
        e.illegal = ill;
`else
        if (ill) e.wb_en = wb;
`endif
        return e;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] low);
        return {op, rd, rs1, low};
    endfunction

    // Present one instruction until accepted; called #1 after a rising edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                        input decoded_t e);
        logic taken = 1'b0;
        instr = ins; rf_rdata1 = d1; rf_rdata2 = d2; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            taken = in_ready;
            @(posedge clk);
            if (taken) break;
            #1;
        end
        if (taken) exp_q.push_back(e);
        else check("accept_timeout", 128'(taken), 128'(1'b1));
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
        check({tag, "_entry"}, 128'(got), 128'(mk_exp(EXE_ADD, 0, 0, 0, 1'b0, 1'b0)));
    endtask

    // Monitor: compare on every output handshake and check hold-while-stalled.
    decoded_t prev;
    logic     prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) check("hold_stable", 128'(got), 128'(prev));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h required no output (t=%0t)", got, $time);
                end else begin
                    check("decode", 128'(got), 128'(exp_q.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev       = got;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_in_ready", 128'(in_ready), 128'(1'b0));
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_in_ready", 128'(in_ready), 128'(1'b1));
        @(posedge clk); #1;

        // Register read addresses are combinational from instr
        out_ready = 1'b1;
        instr = 32'h0422_1800;
        #1;
        check("raddr1", 128'(rf_raddr1), 128'(5'd2));
        check("raddr2", 128'(rf_raddr2), 128'(5'd3));
        @(posedge clk); #1;

        // ADD r1,r2,r3 with one-cycle latency
        send(32'h0422_1800, 32'd5, 32'd7, mk_exp(EXE_ADD, 32'd5, 32'd7, 5'd1, 1'b1, 1'b0));
        @(negedge clk);
        check("latency_out_valid", 128'(out_valid), 128'(1'b1));
        @(posedge clk); #1;

        // Immediate forms; rdata2 carries junk that must not appear
        send(32'h8422_FFFF, 32'd10, 32'hDEAD_BEEF, mk_exp(EXE_ADD, 32'd10, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0));
        send(32'h8C22_FFFF, 32'd10, 32'hDEAD_BEEF, mk_exp(EXE_AND, 32'd10, 32'h0000_FFFF, 5'd1, 1'b1, 1'b0));
        send(32'hA022_0123, 32'd10, 32'hDEAD_BEEF, mk_exp(EXE_SLL, 32'd10, 32'd3, 5'd1, 1'b1, 1'b0));
        // Back-to-back stream at full rate: four accepts in four edges
        c0 = cyc;
        send(mk(6'h22, 5'd3, 5'd4, 16'h8000), 32'd1, 32'd9,
             mk_exp(EXE_SUB, 32'd1, 32'hFFFF_8000, 5'd3, 1'b1, 1'b0));
        send(mk(6'h29, 5'd5, 5'd6, 16'hFFFF), 32'h8000_0000, 32'd9,
             mk_exp(EXE_SRA, 32'h8000_0000, 32'd31, 5'd5, 1'b1, 1'b0));
        send(mk(6'h06, 5'd31, 5'd1, {5'd2, 11'd0}), 32'h0F, 32'hF0,
             mk_exp(EXE_NOR, 32'h0F, 32'hF0, 5'd31, 1'b1, 1'b0));
        send(mk(6'h25, 5'd8, 5'd9, 16'h8001), 32'h55, 32'd9,
             mk_exp(EXE_XOR, 32'h55, 32'h0000_8001, 5'd8, 1'b1, 1'b0));
        check("throughput_edges", 128'(cyc - c0), 128'(4));
        send(mk(6'h0A, 5'd4, 5'd5, {5'd6, 11'd0}), 32'h1234, 32'h4,
             mk_exp(EXE_SRL, 32'h1234, 32'h4, 5'd4, 1'b1, 1'b0));
        wait_drain();

        // Backpressure: A and B buffered, C held off until drain
        #1 out_ready = 1'b0;
        send(mk(6'h01, 5'd10, 5'd1, 16'h0), 32'hA, 32'hA0, mk_exp(EXE_ADD, 32'hA, 32'hA0, 5'd10, 1'b1, 1'b0));
        send(mk(6'h02, 5'd11, 5'd1, 16'h0), 32'hB, 32'hB0, mk_exp(EXE_SUB, 32'hB, 32'hB0, 5'd11, 1'b1, 1'b0));
        instr = mk(6'h03, 5'd12, 5'd1, 16'h0); in_valid = 1'b1;
        check("skid_full_in_ready", 128'(in_ready), 128'(1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("stall_in_ready", 128'(in_ready), 128'(1'b0));
        check("stall_out_valid", 128'(out_valid), 128'(1'b1));
        out_ready = 1'b1;
        send(mk(6'h03, 5'd12, 5'd1, 16'h0), 32'hC, 32'hC0, mk_exp(EXE_AND, 32'hC, 32'hC0, 5'd12, 1'b1, 1'b0));
        wait_drain();

        // Flush with two entries buffered and a same-cycle incoming instruction
        #1 out_ready = 1'b0;
        send(mk(6'h04, 5'd13, 5'd1, 16'h0), 32'hD, 32'hD0, mk_exp(EXE_OR, 32'hD, 32'hD0, 5'd13, 1'b1, 1'b0));
        send(mk(6'h05, 5'd14, 5'd1, 16'h0), 32'hE, 32'hE0, mk_exp(EXE_XOR, 32'hE, 32'hE0, 5'd14, 1'b1, 1'b0));
        instr = mk(6'h01, 5'd15, 5'd1, 16'h0); in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", 128'(out_valid), 128'(1'b0));
        check("flush_in_ready", 128'(in_ready), 128'(1'b1));
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("flush_dropped", 128'(out_valid), 128'(1'b0));
        @(posedge clk); #1;

        // Undefined opcodes decode as NOP; only they flag illegal
        send(mk(6'h3F, 5'd7, 5'd2, 16'h1234), 32'd99, 32'd98, mk_exp(EXE_ADD, 0, 0, 0, 1'b0, 1'b1));
        send(32'h0000_0000, 32'd99, 32'd98, mk_exp(EXE_ADD, 0, 0, 0, 1'b0, 1'b0));
        send(mk(6'h0B, 5'd7, 5'd2, 16'h1234), 32'd99, 32'd98, mk_exp(EXE_ADD, 0, 0, 0, 1'b0, 1'b1));
        send(mk(6'h20, 5'd7, 5'd2, 16'h1234), 32'd99, 32'd98, mk_exp(EXE_ADD, 0, 0, 0, 1'b0, 1'b1));
        send(mk(6'h2B, 5'd7, 5'd2, 16'h1234), 32'd99, 32'd98, mk_exp(EXE_ADD, 0, 0, 0, 1'b0, 1'b1));
        send(mk(6'h01, 5'd7, 5'd2, {5'd3, 11'd0}), 32'd99, 32'd98,
             mk_exp(EXE_ADD, 32'd99, 32'd98, 5'd7, 1'b1, 1'b0));
        wait_drain();

        // One-cycle reset mid-stream discards the buffered entry
        #1 out_ready = 1'b0;
        send(mk(6'h07, 5'd16, 5'd1, 16'h0), 32'h6, 32'h60, mk_exp(EXE_SLA, 32'h6, 32'h60, 5'd16, 1'b1, 1'b0));
        instr = mk(6'h01, 5'd17, 5'd1, 16'h0); in_valid = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle("mid_reset");
        check("mid_reset_in_ready", 128'(in_ready), 128'(1'b0));
        @(posedge clk); #1 out_ready = 1'b1;
        send(mk(6'h02, 5'd2, 5'd3, {5'd4, 11'd0}), 32'd20, 32'd8,
             mk_exp(EXE_SUB, 32'd20, 32'd8, 5'd2, 1'b1, 1'b0));
        wait_drain();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
